ins_cache: RTL

- Direct-mapped, one-word-per-line instruction cache between the instruction fetch unit (IFU) and the memory controller.
- Hits return an instruction combinationally in the request cycle.
- A miss latches the word-aligned address and drives the memory controller fetch handshake (is_fetch/fetch_addr → is_back/back_ins) until the word returns.
- The returned word fills the line; the held IFU request then hits on the following cycle.

---
 rtl/ins_cache.sv | 108 ++++++++++
 1 files changed

// File: rtl/ins_cache.sv
// Direct-mapped, one-word-per-line instruction cache between the IFU and the memory controller.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt statistics outputs.
module ins_cache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    input  logic        clear_in,
    output logic        ins_valid,
    output logic [31:0] ins_out,
    output logic        is_fetch,
    output logic [31:0] fetch_addr,
    input  logic        is_back,
    input  logic [31:0] back_ins
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_arr  [LINES];
    logic [31:0]           data_arr [LINES];
    logic [29:0]           miss_word;
    logic [INDEX_BITS-1:0] idx, miss_idx;
    logic [TAG_W-1:0]      tag, miss_tag;
    logic                  hit, launch, fill;
    logic                  unused_addr_lsbs;

    assign idx      = ifu_addr[INDEX_BITS+1:2];
    assign tag      = ifu_addr[31:INDEX_BITS+2];
    assign miss_idx = miss_word[INDEX_BITS-1:0];
    assign miss_tag = miss_word[29:INDEX_BITS];
    assign unused_addr_lsbs = &{1'b0, ifu_addr[1:0]};

    assign hit        = ifu_req & valid_q[idx] & (tag_arr[idx] == tag);
    assign ins_valid  = hit & ~clear_in & rdy_in;
    assign ins_out    = data_arr[idx];
    // The miss address is only ever word aligned, so just the word index is stored.
    assign is_fetch   = (state_q == FETCH);
    assign fetch_addr = {miss_word, 2'b00};

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        fill    = 1'b0;
        if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (ifu_req && !hit && !clear_in) begin
                        launch  = 1'b1;
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    // clear_in does not abort: an accepted fetch always completes.
                    if (is_back) begin
                        fill    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            miss_word <= '0;
        end else begin
            state_q <= state_d;
            if (launch) miss_word <= ifu_addr[31:2];
            if (fill) valid_q[miss_idx] <= 1'b1;
        end
    end

    // Tag/data storage needs no reset; valid_q gates every use.
    always_ff @(posedge clk_in) begin
        if (fill) begin
            data_arr[miss_idx] <= back_ins;
            tag_arr[miss_idx]  <= miss_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (ins_valid) hit_cnt <= hit_cnt + 32'd1;
            if (launch) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule
